// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, branch resolution, data RAM and MEM/WB register.
// Define MEM_WAIT_EN to add a one-cycle wait state (IDLE/WAIT FSM) to every load/store.
module mem_stage #(
    parameter int ALU_WIDTH      = 8,
    parameter int PC_WIDTH       = 6,
    parameter int REG_DIR_WIDTH  = 3,
    parameter int MEM_ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ALU_WIDTH-1:0]     ex_ALUResult,
    input  logic                     ex_Zero,
    input  logic [PC_WIDTH-1:0]      ex_ALUR,
    input  logic [REG_DIR_WIDTH-1:0] ex_WriteReg,
    input  logic [ALU_WIDTH-1:0]     ex_StoreData,
    input  logic                     ex_Branch,
    input  logic                     ex_MemRead,
    input  logic                     ex_MemWrite,
    input  logic                     ex_RegWrite,
    input  logic                     ex_MemtoReg,
    input  logic                     ex_flush,
    output logic                     PCSrc,
    output logic [PC_WIDTH-1:0]      BranchTarget,
    output logic                     flush_out,
    output logic                     stall_out,
    output logic [ALU_WIDTH-1:0]     wb_ReadData,
    output logic [ALU_WIDTH-1:0]     wb_ALUResult,
    output logic [REG_DIR_WIDTH-1:0] wb_WriteReg,
    output logic                     wb_RegWrite,
    output logic                     wb_MemtoReg
);

    typedef struct packed {
        logic [ALU_WIDTH-1:0]     alu_result;
        logic [ALU_WIDTH-1:0]     store_data;
        logic [PC_WIDTH-1:0]      alur;
        logic [REG_DIR_WIDTH-1:0] write_reg;
        logic                     zero;
        logic                     branch;
        logic                     mem_read;
        logic                     mem_write;
        logic                     reg_write;
        logic                     memto_reg;
    } exmem_t;

    localparam int RAM_WORDS = 1 << MEM_ADDR_WIDTH;

    exmem_t                    m;
    exmem_t                    ex_in;
    logic [ALU_WIDTH-1:0]      ram [RAM_WORDS];
    logic [MEM_ADDR_WIDTH-1:0] ram_idx;
    logic [ALU_WIDTH-1:0]      ram_rd;
    logic                      bubble;

    always_comb begin
        ex_in            = '0;
        ex_in.alu_result = ex_ALUResult;
        ex_in.store_data = ex_StoreData;
        ex_in.alur       = ex_ALUR;
        ex_in.write_reg  = ex_WriteReg;
        ex_in.zero       = ex_Zero;
        ex_in.branch     = ex_Branch;
        ex_in.mem_read   = ex_MemRead;
        ex_in.mem_write  = ex_MemWrite;
        ex_in.reg_write  = ex_RegWrite;
        ex_in.memto_reg  = ex_MemtoReg;
    end

    // A taken branch squashes the wrong-path instruction sitting in EX this cycle.
    assign PCSrc        = m.branch & m.zero;
    assign flush_out    = PCSrc;
    assign BranchTarget = m.alur;
    assign bubble       = ex_flush | PCSrc;

    assign ram_idx = m.alu_result[MEM_ADDR_WIDTH-1:0];
    assign ram_rd  = ram[ram_idx];

`ifdef MEM_WAIT_EN
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state;
    logic   stall_q;

    // stall_q is high exactly in the IDLE cycle following the latch of a load/store.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            stall_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  state <= stall_q ? S_WAIT : S_IDLE;
                default: state <= S_IDLE;
            endcase
            stall_q <= ~stall_q & ~bubble & (ex_MemRead | ex_MemWrite);
        end
    end

    assign stall_out = stall_q;
`else
    assign stall_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)          m <= '0;
        else if (stall_out) m <= m;
        else if (bubble)    m <= '0;
        else                m <= ex_in;
    end

    // Reset also drops a store that is still waiting to complete.
    always_ff @(posedge clk) begin
        if (!reset && !stall_out && m.mem_write)
            ram[ram_idx] <= m.store_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ReadData  <= '0;
            wb_ALUResult <= '0;
            wb_WriteReg  <= '0;
            wb_RegWrite  <= 1'b0;
            wb_MemtoReg  <= 1'b0;
        end else begin
            wb_ReadData  <= ram_rd;
            wb_ALUResult <= m.alu_result;
            wb_WriteReg  <= m.write_reg;
            wb_RegWrite  <= m.reg_write & ~stall_out;
            wb_MemtoReg  <= m.memto_reg & ~stall_out;
        end
    end

endmodule
